// File: rtl/setup_config_if.sv
// Record types and the handshake/keypad/display bundle between the lock FSM and the
// setup editor. The bench drives the master side; setup_config sits on the slave side.
package setup_config_pkg;
  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pin_t;

  typedef struct packed {
    logic        bip_status;
    logic [15:0] bip_time;
    logic [15:0] tranca_aut_time;
    pin_t        master_pin;
    pin_t        pin1;
    pin_t        pin2;
    pin_t        pin3;
    pin_t        pin4;
  } setupPac_t;

  typedef struct packed {
    logic [3:0] d5;
    logic [3:0] d4;
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcdPac_t;
endpackage

interface setup_config_if;
  import setup_config_pkg::*;

  logic      setup_on;
  logic      key_valid;
  logic [3:0] key_code;
  setupPac_t data_setup_old;
  setupPac_t data_setup_new;
  logic      setup_end;
  bcdPac_t   bcd_out;
  logic      bcd_enable;

  modport master (
    output setup_on, key_valid, key_code, data_setup_old,
    input  data_setup_new, setup_end, bcd_out, bcd_enable
  );

  modport slave (
    input  setup_on, key_valid, key_code, data_setup_old,
    output data_setup_new, setup_end, bcd_out, bcd_enable
  );
endinterface

// File: rtl/setup_config.sv
// Keypad-driven editor for the seven setup parameters; snapshots the current record,
// validates each entry and returns the edited (or untouched, on abort) record.
module setup_config
  import setup_config_pkg::*;
#(
  parameter int unsigned TIMEOUT = 30000
) (
  input logic           clk,
  input logic           rst,
  setup_config_if.slave bus
);

  localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bcdPac_t     BLANK = 24'hFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_EDIT     = 3'd2,
    S_CHECK    = 3'd3,
    S_DONE     = 3'd4,
    S_WAIT_LOW = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               setup_on_q, setup_on_prev_q;
  logic               key_valid_q, key_valid_dly_q;
  logic [3:0]         key_code_q;
  logic [2:0]         step_q, step_d;
  logic [15:0]        entry_q, entry_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               dis_q, dis_d;
  setupPac_t          work_q, work_d;
  setupPac_t          snap_q, snap_d;
  setupPac_t          new_q, new_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               end_q, end_d;
  logic               en_q, en_d;
  bcdPac_t            bcd_q, bcd_d;

  logic               key_edge_s, on_rise_s, ok_s;
  setupPac_t          w_s;
  pin_t               p_s;
  logic [6:0]         val_s;
  logic [15:0]        ms_s;
  logic [3:0]         others_s;

  function automatic logic [2:0] cap_of(input logic [2:0] step);
    case (step)
      3'd1:       return 3'd1;
      3'd2, 3'd3: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

  // One or two typed digits as a decimal value.
  function automatic logic [6:0] dec2(input logic [7:0] b, input logic [2:0] n);
    logic [6:0] tens;
    tens = {3'b000, b[7:4]};
    if (n == 3'd1) return {3'b000, b[3:0]};
    else           return (tens << 3) + (tens << 1) + {3'b000, b[3:0]};
  endfunction

  function automatic pin_t get_pin(input setupPac_t s, input logic [1:0] idx);
    case (idx)
      2'd0:    return s.pin1;
      2'd1:    return s.pin2;
      2'd2:    return s.pin3;
      default: return s.pin4;
    endcase
  endfunction

  function automatic setupPac_t set_pin(input setupPac_t s, input logic [1:0] idx, input pin_t p);
    setupPac_t r;
    r = s;
    case (idx)
      2'd0:    r.pin1 = p;
      2'd1:    r.pin2 = p;
      2'd2:    r.pin3 = p;
      default: r.pin4 = p;
    endcase
    return r;
  endfunction

  function automatic bcdPac_t disp(input logic en, input logic [2:0] step,
                                   input logic [15:0] b, input logic [2:0] n);
    bcdPac_t r;
    r = BLANK;
    if (en) begin
      r.d5 = {1'b0, step};
      r.d0 = (n >= 3'd1) ? b[3:0]   : 4'hF;
      r.d1 = (n >= 3'd2) ? b[7:4]   : 4'hF;
      r.d2 = (n >= 3'd3) ? b[11:8]  : 4'hF;
      r.d3 = (n >= 3'd4) ? b[15:12] : 4'hF;
    end else begin
      r = BLANK;
    end
    return r;
  endfunction

  assign key_edge_s = key_valid_q & ~key_valid_dly_q;
  assign on_rise_s  = setup_on_q & ~setup_on_prev_q;

  // Next-state, datapath and registered-output precompute.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    entry_d  = entry_q;
    cnt_d    = cnt_q;
    dis_d    = dis_q;
    work_d   = work_q;
    snap_d   = snap_q;
    new_d    = new_q;
    tmo_d    = tmo_q;
    ok_s     = 1'b0;
    w_s      = work_q;
    p_s      = get_pin(work_q, step_q[1:0]);
    val_s    = dec2(entry_q[7:0], cnt_q);
    ms_s     = {9'd0, val_s} * 16'd1000;
    others_s = {work_q.pin4.status, work_q.pin3.status, work_q.pin2.status, work_q.pin1.status}
               & ~(4'b0001 << step_q[1:0]);

    case (state_q)
      S_IDLE: begin
        if (on_rise_s) begin
          state_d = S_LOAD;
          step_d  = 3'd1;
          entry_d = 16'd0;
          cnt_d   = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        if (!setup_on_q) begin
          state_d = S_IDLE;
        end else begin
          work_d  = bus.data_setup_old;
          snap_d  = bus.data_setup_old;
          step_d  = 3'd1;
          entry_d = 16'd0;
          cnt_d   = 3'd0;
          dis_d   = 1'b0;
          tmo_d   = {TMO_W{1'b0}};
          state_d = S_EDIT;
        end
      end

      S_EDIT: begin
        if (!setup_on_q) begin
          state_d = S_IDLE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          new_d   = snap_q;
          state_d = S_DONE;
        end else if (key_edge_s) begin
          tmo_d = {TMO_W{1'b0}};
          case (key_code_q)
            4'hE: begin
              if (cnt_q != 3'd0) begin
                entry_d = 16'd0;
                cnt_d   = 3'd0;
              end else begin
                new_d   = snap_q;
                state_d = S_DONE;
              end
            end
            4'hA: begin
              if (step_q[2]) begin
                dis_d   = 1'b1;
                state_d = S_CHECK;
              end else begin
                dis_d   = 1'b0;
              end
            end
            4'hF: begin
              dis_d   = 1'b0;
              state_d = S_CHECK;
            end
            4'hB, 4'hC, 4'hD: begin
              tmo_d = tmo_q + TMO_W'(1);
            end
            default: begin
              if (cnt_q < cap_of(step_q)) begin
                entry_d = {entry_q[11:0], key_code_q};
                cnt_d   = cnt_q + 3'd1;
              end else begin
                entry_d = entry_q;
              end
            end
          endcase
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_CHECK: begin
        if (!setup_on_q) begin
          state_d = S_IDLE;
        end else begin
          if (dis_q) begin
            // Refuse to disable the last enabled user pin.
            if (others_s != 4'd0) begin
              ok_s         = 1'b1;
              p_s.status   = 1'b0;
              w_s          = set_pin(work_q, step_q[1:0], p_s);
            end else begin
              ok_s = 1'b0;
            end
          end else if (cnt_q == 3'd0) begin
            ok_s = 1'b1;
          end else begin
            case (step_q)
              3'd1: begin
                if ((cnt_q == 3'd1) && (entry_q[3:0] <= 4'd1)) begin
                  ok_s           = 1'b1;
                  w_s.bip_status = entry_q[0];
                end else begin
                  ok_s = 1'b0;
                end
              end
              3'd2, 3'd3: begin
                if ((val_s >= 7'd5) && (val_s <= 7'd60)) begin
                  ok_s = 1'b1;
                  if (step_q == 3'd2) w_s.bip_time        = ms_s;
                  else                w_s.tranca_aut_time = ms_s;
                end else begin
                  ok_s = 1'b0;
                end
              end
              default: begin
                if (cnt_q == 3'd4) begin
                  ok_s = 1'b1;
                  w_s  = set_pin(work_q, step_q[1:0],
                                 {1'b1, entry_q[15:12], entry_q[11:8], entry_q[7:4], entry_q[3:0]});
                end else begin
                  ok_s = 1'b0;
                end
              end
            endcase
          end

          entry_d = 16'd0;
          cnt_d   = 3'd0;
          dis_d   = 1'b0;
          if (ok_s && (step_q == 3'd7)) begin
            work_d  = w_s;
            new_d   = w_s;
            state_d = S_DONE;
          end else if (ok_s) begin
            work_d  = w_s;
            step_d  = step_q + 3'd1;
            state_d = S_EDIT;
          end else begin
            state_d = S_EDIT;
          end
        end
      end

      S_DONE: state_d = S_WAIT_LOW;

      S_WAIT_LOW: begin
        if (!setup_on_q) state_d = S_IDLE;
        else             state_d = S_WAIT_LOW;
      end

      default: state_d = S_IDLE;
    endcase

    en_d  = (state_d == S_LOAD) || (state_d == S_EDIT) || (state_d == S_CHECK);
    bcd_d = disp(en_d, step_d, entry_d, cnt_d);
    end_d = (state_d == S_DONE);
  end

  // State, working record and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      setup_on_q      <= 1'b0;
      setup_on_prev_q <= 1'b0;
      key_valid_q     <= 1'b0;
      key_valid_dly_q <= 1'b0;
      key_code_q      <= 4'd0;
      step_q          <= 3'd0;
      entry_q         <= 16'd0;
      cnt_q           <= 3'd0;
      dis_q           <= 1'b0;
      work_q          <= '0;
      snap_q          <= '0;
      new_q           <= '0;
      tmo_q           <= {TMO_W{1'b0}};
      end_q           <= 1'b0;
      en_q            <= 1'b0;
      bcd_q           <= BLANK;
    end else begin
      state_q         <= state_d;
      setup_on_q      <= bus.setup_on;
      setup_on_prev_q <= setup_on_q;
      key_valid_q     <= bus.key_valid;
      key_valid_dly_q <= key_valid_q;
      key_code_q      <= bus.key_code;
      step_q          <= step_d;
      entry_q         <= entry_d;
      cnt_q           <= cnt_d;
      dis_q           <= dis_d;
      work_q          <= work_d;
      snap_q          <= snap_d;
      new_q           <= new_d;
      tmo_q           <= tmo_d;
      end_q           <= end_d;
      en_q            <= en_d;
      bcd_q           <= bcd_d;
    end
  end

  assign bus.data_setup_new = new_q;
  assign bus.setup_end      = end_q;
  assign bus.bcd_out        = bcd_q;
  assign bus.bcd_enable     = en_q;

endmodule

// File: tb/tb_setup_config.sv
// Bench for setup_config: keypad vector table per session, expected records queued at
// session start and compared when setup_end pulses.
module tb_setup_config;
  import setup_config_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  setup_config_if bus ();
  setup_config #(.TIMEOUT(30000)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0]  key;
    logic        en;
    logic [3:0]  step;
    logic [15:0] entry;
  } vec_t;

  vec_t      vecs[$];
  setupPac_t expq[$];
  setupPac_t exp_cur, exp_last, old_s, garbage_s;
  int        errors = 0;
  int        checks = 0;
  int        pulses = 0;
  logic      end_prev = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard side: every setup_end pulse must match the oldest queued record.
  always @(negedge clk) begin
    if (rst) begin
      end_prev = 1'b0;
    end else begin
      if (bus.setup_end) begin
        pulses++;
        chk("end_single_cycle", 128'(end_prev), 128'(0));
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_end: got pulse expected none at %0t", $time);
        end else begin
          exp_cur = expq.pop_front();
          chk("data_setup_new", 128'(bus.data_setup_new), 128'(exp_cur));
        end
      end
      end_prev = bus.setup_end;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start_session();
    bus.setup_on = 1'b1;
    cyc(4);
  endtask

  task automatic stop_session();
    bus.setup_on = 1'b0;
    cyc(3);
  endtask

  task automatic press(input logic [3:0] k);
    bus.key_code  = k;
    bus.key_valid = 1'b1;
    cyc(1);
    bus.key_valid = 1'b0;
    cyc(3);
  endtask

  task automatic check_disp(input string name, input logic en, input logic [3:0] st, input logic [15:0] e);
    chk($sformatf("%s_en", name), 128'(bus.bcd_enable), 128'(en));
    chk($sformatf("%s_bcd", name), 128'(bus.bcd_out), en ? 128'({st, 4'hF, e}) : 128'(24'hFF_FFFF));
  endtask

  task automatic add(input logic [3:0] k, input logic en, input logic [3:0] st, input logic [15:0] e);
    vec_t v;
    v.key = k; v.en = en; v.step = st; v.entry = e;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tag, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      press(vecs[i].key);
      check_disp($sformatf("%s_v%0d", tag, i - lo), vecs[i].en, vecs[i].step, vecs[i].entry);
    end
  endtask

  function automatic setupPac_t mk_old(input logic p2);
    setupPac_t s;
    s = '0;
    s.bip_time        = 16'd3000;
    s.tranca_aut_time = 16'd5000;
    s.master_pin      = {1'b1, 4'd9, 4'd9, 4'd9, 4'd9};
    s.pin1            = {1'b1, 4'd1, 4'd2, 4'd3, 4'd4};
    s.pin2            = {p2,   4'd4, 4'd3, 4'd2, 4'd1};
    s.pin4            = {1'b0, 4'd7, 4'd7, 4'd7, 4'd7};
    return s;
  endfunction

  initial begin
    int a0, a1, b1, c1, d1, e1, p0, k;

    // Session A: full edit
    a0 = vecs.size();
    add(4'h1,1,1,16'hFFF1); add(4'hF,1,2,16'hFFFF); add(4'h1,1,2,16'hFFF1); add(4'h0,1,2,16'hFF10);
    add(4'hF,1,3,16'hFFFF); add(4'h2,1,3,16'hFFF2); add(4'h0,1,3,16'hFF20); add(4'hF,1,4,16'hFFFF);
    add(4'h5,1,4,16'hFFF5); add(4'h6,1,4,16'hFF56); add(4'h7,1,4,16'hF567); add(4'h8,1,4,16'h5678);
    add(4'hF,1,5,16'hFFFF); add(4'hF,1,6,16'hFFFF); add(4'hF,1,7,16'hFFFF); add(4'hF,0,0,16'hFFFF);
    // Session B: range rejects and boundaries
    a1 = vecs.size();
    add(4'h2,1,1,16'hFFF2); add(4'hF,1,1,16'hFFFF); add(4'hF,1,2,16'hFFFF);
    add(4'h4,1,2,16'hFFF4); add(4'hF,1,2,16'hFFFF);
    add(4'h6,1,2,16'hFFF6); add(4'h1,1,2,16'hFF61); add(4'hF,1,2,16'hFFFF);
    add(4'h1,1,2,16'hFFF1); add(4'h2,1,2,16'hFF12); add(4'h3,1,2,16'hFF12); add(4'hE,1,2,16'hFFFF);
    add(4'h6,1,2,16'hFFF6); add(4'h0,1,2,16'hFF60); add(4'hF,1,3,16'hFFFF);
    add(4'h5,1,3,16'hFFF5); add(4'hA,1,3,16'hFFF5); add(4'hF,1,4,16'hFFFF);
    add(4'hB,1,4,16'hFFFF); add(4'h1,1,4,16'hFFF1); add(4'hF,1,4,16'hFFFF);
    add(4'hF,1,5,16'hFFFF); add(4'hF,1,6,16'hFFFF); add(4'hF,1,7,16'hFFFF); add(4'hF,0,0,16'hFFFF);
    // Session C: disabling the only active pin is refused, then cancel
    b1 = vecs.size();
    add(4'hA,1,1,16'hFFFF); add(4'hF,1,2,16'hFFFF); add(4'hF,1,3,16'hFFFF); add(4'hF,1,4,16'hFFFF);
    add(4'hA,1,4,16'hFFFF); add(4'hE,0,0,16'hFFFF);
    // Session D: pin2 active, so pin1 may be disabled
    c1 = vecs.size();
    add(4'hF,1,2,16'hFFFF); add(4'hF,1,3,16'hFFFF); add(4'hF,1,4,16'hFFFF); add(4'hA,1,5,16'hFFFF);
    add(4'hF,1,6,16'hFFFF); add(4'hF,1,7,16'hFFFF); add(4'hF,0,0,16'hFFFF);
    // Session E: edits then double cancel at step 3
    d1 = vecs.size();
    add(4'h1,1,1,16'hFFF1); add(4'hF,1,2,16'hFFFF); add(4'h1,1,2,16'hFFF1); add(4'h5,1,2,16'hFF15);
    add(4'hF,1,3,16'hFFFF); add(4'h3,1,3,16'hFFF3); add(4'hE,1,3,16'hFFFF); add(4'hE,0,0,16'hFFFF);
    e1 = vecs.size();

    rst = 1'b1;
    bus.setup_on = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code = 4'h0;
    bus.data_setup_old = mk_old(1'b0);
    cyc(2);
    chk("rst_setup_end", 128'(bus.setup_end), 128'(0));
    chk("rst_bcd_enable", 128'(bus.bcd_enable), 128'(0));
    chk("rst_bcd_out", 128'(bus.bcd_out), 128'(24'hFF_FFFF));
    chk("rst_data_new", 128'(bus.data_setup_new), 128'(0));
    rst = 1'b0;
    cyc(2);
    check_disp("idle", 1'b0, 4'h0, 16'hFFFF);

    // Session A
    old_s = mk_old(1'b0);
    bus.data_setup_old = old_s;
    exp_cur = old_s;
    exp_cur.bip_status = 1'b1;
    exp_cur.bip_time = 16'd10000;
    exp_cur.tranca_aut_time = 16'd20000;
    exp_cur.pin1 = {1'b1, 4'd5, 4'd6, 4'd7, 4'd8};
    expq.push_back(exp_cur);
    exp_last = exp_cur;
    p0 = pulses;
    start_session();
    check_disp("start", 1'b1, 4'h1, 16'hFFFF);
    run_vecs("full", a0, a1);
    chk("full_pulses", 128'(pulses), 128'(p0 + 1));
    cyc(20);
    chk("hold_no_restart", 128'(pulses), 128'(p0 + 1));
    check_disp("hold", 1'b0, 4'h0, 16'hFFFF);
    chk("hold_data_new", 128'(bus.data_setup_new), 128'(exp_last));
    stop_session();

    // Session B
    exp_cur = old_s;
    exp_cur.bip_time = 16'd60000;
    exp_cur.tranca_aut_time = 16'd5000;
    expq.push_back(exp_cur);
    start_session();
    run_vecs("range", a1, b1);

    // Session C
    stop_session();
    expq.push_back(old_s);
    start_session();
    run_vecs("lastpin", b1, c1);
    stop_session();

    // Session D
    old_s = mk_old(1'b1);
    bus.data_setup_old = old_s;
    exp_cur = old_s;
    exp_cur.pin1.status = 1'b0;
    expq.push_back(exp_cur);
    start_session();
    run_vecs("dispin", c1, d1);
    stop_session();

    // Session E: the snapshot must survive a change on data_setup_old
    old_s = mk_old(1'b0);
    bus.data_setup_old = old_s;
    expq.push_back(old_s);
    exp_last = old_s;
    start_session();
    garbage_s = ~old_s;
    bus.data_setup_old = garbage_s;
    run_vecs("cancel", d1, e1);
    stop_session();
    bus.data_setup_old = old_s;

    // setup_on drop mid-EDIT
    p0 = pulses;
    start_session();
    press(4'h5);
    check_disp("drop_pre", 1'b1, 4'h1, 16'hFFF5);
    stop_session();
    check_disp("drop", 1'b0, 4'h0, 16'hFFFF);
    chk("drop_no_pulse", 128'(pulses), 128'(p0));
    chk("drop_data_new", 128'(bus.data_setup_new), 128'(exp_last));

    // rst mid-EDIT
    start_session();
    press(4'h1);
    rst = 1'b1;
    #1;
    chk("midrst_setup_end", 128'(bus.setup_end), 128'(0));
    chk("midrst_bcd_enable", 128'(bus.bcd_enable), 128'(0));
    chk("midrst_bcd_out", 128'(bus.bcd_out), 128'(24'hFF_FFFF));
    chk("midrst_data_new", 128'(bus.data_setup_new), 128'(0));
    bus.setup_on = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(3);
    chk("midrst_no_pulse", 128'(pulses), 128'(p0));

    // Inactivity: a key just before expiry restarts the count
    expq.push_back(old_s);
    start_session();
    cyc(29996);
    chk("tmo_pre_pulse", 128'(pulses), 128'(p0));
    check_disp("tmo_pre", 1'b1, 4'h1, 16'hFFFF);
    press(4'h1);
    cyc(29990);
    chk("tmo_restart_pulse", 128'(pulses), 128'(p0));
    check_disp("tmo_restart", 1'b1, 4'h1, 16'hFFF1);
    k = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (pulses != p0) begin
        k = i;
        break;
      end
    end
    chk("tmo_cycle", 128'(k), 128'(8));
    stop_session();

    chk("queue_drained", 128'(expq.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
